// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int SA_WIDTH_MIN = 1;
   localparam int SA_WIDTH_MAX = 32;

endpackage

// File: rtl/full_adder_cell.sv
// Gate-level 1-bit full adder; the single arithmetic cell of the serial adder.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic carry
);

   logic ab_xor;
   logic ab_and;
   logic cx_and;

   assign ab_xor = a ^ b;
   assign ab_and = a & b;
   assign cx_and = ab_xor & c_in;
   assign sum    = ab_xor ^ c_in;
   assign carry  = ab_and | cx_and;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first over WIDTH cycles using one full-adder cell.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf_out
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   if (WIDTH < SA_WIDTH_MIN || WIDTH > SA_WIDTH_MAX) begin : g_width_check
      $error("serial_adder: WIDTH out of range");
   end

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res_reg;
   logic [WIDTH-1:0] res_next;
   logic [CW-1:0]    cnt_reg;
   logic             carry_reg;
   logic             cell_sum;
   logic             cell_carry;
   logic             last_bit;

   full_adder_cell u_cell (
      .a     (a_reg[0]),
      .b     (b_reg[0]),
      .c_in  (carry_reg),
      .sum   (cell_sum),
      .carry (cell_carry)
   );

   // New sum bit enters at the MSB so the LSB-first result lands in place after WIDTH shifts.
   if (WIDTH == 1) begin : g_res_one
      assign res_next = cell_sum;
   end else begin : g_res_wide
      assign res_next = {cell_sum, res_reg[WIDTH-1:1]};
   end

   assign last_bit = (cnt_reg == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum_out   <= '0;
         carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_out   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  a_reg     <= a_in;
                  b_reg     <= b_in;
                  carry_reg <= c_in;
                  cnt_reg   <= '0;
                  busy      <= 1'b1;
                  state_reg <= SHIFT;
               end else begin
                  state_reg <= IDLE;
               end
            end
            SHIFT: begin
               a_reg     <= a_reg >> 1;
               b_reg     <= b_reg >> 1;
               res_reg   <= res_next;
               carry_reg <= cell_carry;
               cnt_reg   <= cnt_reg + CW'(1);
               if (last_bit) begin
                  state_reg <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  sum_out   <= res_next;
                  carry_out <= cell_carry;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry_reg holds the carry into the MSB during the final shift.
                  ovf_out   <= carry_reg ^ cell_carry;
`endif
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around a single gate-level full-adder cell and a carry flip-flop. It sits directly downstream of the full-adder cell and consumes that cell's sum and carry outputs every cycle. Operands are loaded in parallel, summed LSB-first over WIDTH cycles, and the result is presented in parallel with a one-cycle done pulse. It trades latency for area against the ripple-carry adder built from the same cell.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 32.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to load operands and begin an addition.
- a_in  input  WIDTH  operand A, sampled on the accepting edge.
- b_in  input  WIDTH  operand B, sampled on the accepting edge.
- c_in  input  1  carry-in, sampled on the accepting edge.
- busy  output  1  high while bits are being shifted.
- done  output  1  one-cycle pulse; result valid.
- sum_out  output  WIDTH  registered result; held until the next result.
- carry_out  output  1  registered final carry; held with sum_out.
- ovf_out  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- FSM states:
  - IDLE: waiting for start.
  - SHIFT: one result bit per cycle.
  - DONE: publishes the result for one cycle.
- IDLE or DONE, start=1:
  - Load a_in into shift register A and b_in into shift register B.
  - Load c_in into the carry flip-flop; clear the bit counter.
  - Go to SHIFT.
- DONE, start=0: go to IDLE.
- SHIFT, every cycle:
  - The cell computes from A[0], B[0] and the carry flip-flop.
  - Shift the cell's sum into the MSB of the internal result register; shift A and B right.
  - Load the cell's carry into the carry flip-flop; increment the counter.
  - When the counter reaches WIDTH-1 this cycle, go to DONE.
- On entry to DONE:
  - sum_out and carry_out load from the internal result register and the final carry on the same edge.
  - sum_out = (a_in + b_in + c_in) mod 2^WIDTH; carry_out = bit WIDTH of that sum.
- start in SHIFT is ignored: no queueing, no restart, operands unchanged.
- sum_out and carry_out change only on entry to DONE, never mid-operation.
- Counter width is $clog2(WIDTH+1). WIDTH=1 completes after one SHIFT cycle.

## Timing
- Reset (async assert, sync release):
  - state IDLE.
  - busy=0, done=0, sum_out=0, carry_out=0, ovf_out=0.
  - Shift registers, counter and carry flip-flop all 0.
- Edge E0 accepts start. busy is high from E0 through edge E0+WIDTH.
- Result and done appear after edge E0+WIDTH: latency is WIDTH cycles from the accepting edge.
- done is high exactly one cycle.
- Back-to-back operation: start held high during the done cycle is accepted. Issue interval is WIDTH+1 cycles.
- Reset mid-SHIFT aborts immediately. sum_out and carry_out return to 0; no done is produced.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - ovf_out exists.
  - It loads on entry to DONE with (carry into MSB) XOR (carry out of MSB), i.e. two's-complement overflow.
  - The carry into the MSB is captured in a flip-flop during the last SHIFT cycle.
- SERIAL_ADDER_OVF_EN undefined: ovf_out port and its flip-flop are absent; all other behaviour is identical.

## Structure
- Package serial_adder_pkg holds:
  - the FSM state typedef (IDLE, SHIFT, DONE);
  - the WIDTH range limits used by the elaboration-time check.
- One sub-module: full_adder_cell.
  - Gate-level 1-bit adder with ports a, b, c_in, sum, carry.
  - Instantiated once and fed by A[0], B[0] and the carry flip-flop.

## Test plan
All scenarios use WIDTH=8.
- 0x5A + 0x3C, c_in=0 -> after 8 cycles: sum_out=0x96, carry_out=0, done for 1 cycle, busy for 8 cycles.
- 0xFF + 0x01, c_in=0 -> sum_out=0x00, carry_out=1. Then 0xFF + 0x00, c_in=1 -> sum_out=0x00, carry_out=1.
- start pulsed at cycle 3 of SHIFT with different operands -> ignored; the first result is delivered unchanged on schedule.
- rst_n low at cycle 4 of SHIFT -> all outputs 0 immediately. No done follows; the next start yields the correct sum.
- start held high continuously with 0x01+0x01, then 0x10+0x20 -> done every 9 cycles with sum_out 0x02, then 0x30.
- SERIAL_ADDER_OVF_EN: 0x7F + 0x01 -> ovf_out=1, carry_out=0; 0xFF + 0x01 -> ovf_out=0, carry_out=1.
